// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith/shift ops plus iterative shift-add
// MUL and restoring DIVU/REMU, behind valid/ready handshakes on both sides.
module alu_mc #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] din1_alu,
  input  logic [WIDTH-1:0] din2_alu,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] result_alu,
  output logic             ZF,
  output logic             CF,
  output logic             OF,
  output logic             NF,
  output logic             err,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam logic [3:0] OP_AND  = 4'b0000, OP_OR   = 4'b0001, OP_ADD  = 4'b0010,
                         OP_XOR  = 4'b0011, OP_SLL  = 4'b0100, OP_SRL  = 4'b0101,
                         OP_SUB  = 4'b0110, OP_SLTU = 4'b0111, OP_SLT  = 4'b1000,
                         OP_SRA  = 4'b1001, OP_MUL  = 4'b1010, OP_DIVU = 4'b1011,
                         OP_NOR  = 4'b1100, OP_REMU = 4'b1101;

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  state_t           state;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] opa_q;    // MUL: multiplicand; DIV: dividend shifting into quotient
  logic [WIDTH-1:0] opb_q;    // MUL: multiplier;   DIV: divisor
  logic [WIDTH-1:0] acc_q;    // MUL: product accumulator; DIV: partial remainder
  logic [CNT_W-1:0] count_q;

  logic [WIDTH-1:0] sc_result;
  logic             sc_cf, sc_of, sc_err, is_iter;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] diff;
  logic [CNT_W-2:0] shamt;

  // NOTE: every variable written in an always_comb gets a default first, so no
  // path through the case leaves it unassigned and infers a latch.
  always_comb begin
    sc_result = '0;
    sc_cf     = 1'b0;
    sc_of     = 1'b0;
    sc_err    = 1'b0;
    sum       = {1'b0, din1_alu} + {1'b0, din2_alu};
    diff      = din1_alu - din2_alu;
    shamt     = din2_alu[CNT_W-2:0];
    is_iter   = (op == OP_MUL) || ((op == OP_DIVU || op == OP_REMU) && din2_alu != '0);
    case (op)
      OP_AND:  sc_result = din1_alu & din2_alu;
      OP_OR:   sc_result = din1_alu | din2_alu;
      OP_XOR:  sc_result = din1_alu ^ din2_alu;
      OP_NOR:  sc_result = ~(din1_alu | din2_alu);
      OP_SLL:  sc_result = din1_alu << shamt;
      OP_SRL:  sc_result = din1_alu >> shamt;
      OP_SRA:  sc_result = $signed(din1_alu) >>> shamt;
      OP_SLTU: sc_result = {{(WIDTH-1){1'b0}}, din1_alu < din2_alu};
      OP_SLT:  sc_result = {{(WIDTH-1){1'b0}}, $signed(din1_alu) < $signed(din2_alu)};
      OP_ADD: begin
        sc_result = sum[WIDTH-1:0];
        sc_cf     = sum[WIDTH];
        sc_of     = (din1_alu[WIDTH-1] == din2_alu[WIDTH-1]) &&
                    (sum[WIDTH-1] != din1_alu[WIDTH-1]);
      end
      OP_SUB: begin
        sc_result = diff;
        sc_cf     = din1_alu >= din2_alu;
        sc_of     = (din1_alu[WIDTH-1] != din2_alu[WIDTH-1]) &&
                    (diff[WIDTH-1] != din1_alu[WIDTH-1]);
      end
      // Divide by zero bypasses the iteration entirely.
      OP_DIVU: begin sc_result = '1;       sc_err = 1'b1; end
      OP_REMU: begin sc_result = din1_alu; sc_err = 1'b1; end
      OP_MUL:  sc_result = '0;
      default: sc_err = 1'b1;
    endcase
  end

  logic [WIDTH-1:0] step_a, step_b, step_acc, iter_result;
  logic [WIDTH:0]   shifted, trial;

  always_comb begin
    step_a   = opa_q;
    step_b   = opb_q;
    step_acc = acc_q;
    shifted  = '0;
    trial    = '0;
    if (op_q == OP_MUL) begin
      if (opb_q[0]) step_acc = acc_q + opa_q;
      step_a = opa_q << 1;
      step_b = opb_q >> 1;
    end else begin
      shifted = {acc_q, opa_q[WIDTH-1]};
      trial   = shifted - {1'b0, opb_q};
      if (!trial[WIDTH]) begin
        step_acc = trial[WIDTH-1:0];
        step_a   = {opa_q[WIDTH-2:0], 1'b1};
      end else begin
        step_acc = shifted[WIDTH-1:0];
        step_a   = {opa_q[WIDTH-2:0], 1'b0};
      end
    end
    iter_result = (op_q == OP_DIVU) ? step_a : step_acc;
  end

  // NOTE: all state here uses non-blocking assignments so every register samples
  // the pre-edge values and evaluation order inside the block cannot matter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      result_alu <= '0;
      ZF         <= 1'b1;
      CF         <= 1'b0;
      OF         <= 1'b0;
      NF         <= 1'b0;
      err        <= 1'b0;
      op_q       <= '0;
      opa_q      <= '0;
      opb_q      <= '0;
      acc_q      <= '0;
      count_q    <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid && in_ready) begin
          op_q     <= op;
          opa_q    <= din1_alu;
          opb_q    <= din2_alu;
          acc_q    <= '0;
          in_ready <= 1'b0;
          if (is_iter) begin
            state   <= ITER;
            count_q <= CNT_W'(WIDTH);
          end else begin
            state      <= DONE;
            out_valid  <= 1'b1;
            result_alu <= sc_result;
            ZF         <= (sc_result == '0);
            NF         <= sc_result[WIDTH-1];
            CF         <= sc_cf;
            OF         <= sc_of;
            err        <= sc_err;
          end
        end
        ITER: begin
          opa_q   <= step_a;
          opb_q   <= step_b;
          acc_q   <= step_acc;
          count_q <= count_q - CNT_W'(1);
          if (count_q == CNT_W'(1)) begin
            state      <= DONE;
            out_valid  <= 1'b1;
            result_alu <= iter_result;
            ZF         <= (iter_result == '0);
            NF         <= iter_result[WIDTH-1];
            CF         <= 1'b0;
            OF         <= 1'b0;
            err        <= 1'b0;
          end
        end
        DONE: if (out_ready) begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: WIDTH=32 and WIDTH=8 instances, directed
// vector table, handshake/reset corner sequences and randomized model checks.
module tb_alu_mc;

  localparam logic [3:0] OP_AND  = 4'b0000, OP_OR   = 4'b0001, OP_ADD  = 4'b0010,
                         OP_XOR  = 4'b0011, OP_SLL  = 4'b0100, OP_SRL  = 4'b0101,
                         OP_SUB  = 4'b0110, OP_SLTU = 4'b0111, OP_SLT  = 4'b1000,
                         OP_SRA  = 4'b1001, OP_MUL  = 4'b1010, OP_DIVU = 4'b1011,
                         OP_NOR  = 4'b1100, OP_REMU = 4'b1101;

  typedef struct packed {
    logic [31:0] res;
    logic        zf, cf, of, nf, err;
  } out_t;

  typedef struct {
    int         w;
    logic [3:0] op;
    logic [31:0] a, b;
    out_t       exp;
    int         lat;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  op;
  logic [31:0] din1, din2;
  logic        in_valid32, in_valid8, out_ready32, out_ready8;

  logic [31:0] res32;
  logic [7:0]  res8;
  logic        zf32, cf32, of32, nf32, err32, ov32, ir32;
  logic        zf8, cf8, of8, nf8, err8, ov8, ir8;

  int          cur_w;
  logic [31:0] o_res;
  logic        o_zf, o_cf, o_of, o_nf, o_err, o_valid, o_in_ready;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_mc #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .op(op), .din1_alu(din1), .din2_alu(din2),
    .in_valid(in_valid32), .in_ready(ir32), .result_alu(res32),
    .ZF(zf32), .CF(cf32), .OF(of32), .NF(nf32), .err(err32),
    .out_valid(ov32), .out_ready(out_ready32)
  );

  alu_mc #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .op(op), .din1_alu(din1[7:0]), .din2_alu(din2[7:0]),
    .in_valid(in_valid8), .in_ready(ir8), .result_alu(res8),
    .ZF(zf8), .CF(cf8), .OF(of8), .NF(nf8), .err(err8),
    .out_valid(ov8), .out_ready(out_ready8)
  );

  always_comb begin
    if (cur_w == 8) begin
      o_res = {24'h0, res8}; o_zf = zf8; o_cf = cf8; o_of = of8; o_nf = nf8;
      o_err = err8; o_valid = ov8; o_in_ready = ir8;
    end else begin
      o_res = res32; o_zf = zf32; o_cf = cf32; o_of = of32; o_nf = nf32;
      o_err = err32; o_valid = ov32; o_in_ready = ir32;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic longint sx(input logic [63:0] v, input int w);
    if (v[w-1]) return longint'(v) - (longint'(1) << w);
    return longint'(v);
  endfunction

  // Reference: plain arithmetic on wide integers, masked to the instance width.
  function automatic out_t model(input logic [3:0] o, input logic [31:0] a_in,
                                 input logic [31:0] b_in, input int w);
    logic [63:0] mask, a, b, r;
    longint sa, sb, sr, smin, smax;
    int sh;
    out_t m;
    mask = (64'd1 << w) - 64'd1;
    a    = {32'h0, a_in} & mask;
    b    = {32'h0, b_in} & mask;
    sa   = sx(a, w);
    sb   = sx(b, w);
    smax = (longint'(1) << (w - 1)) - 1;
    smin = -(longint'(1) << (w - 1));
    sh   = int'(b[31:0]) & (w - 1);
    m    = '0;
    r    = '0;
    case (o)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NOR:  r = ~(a | b) & mask;
      OP_SLL:  r = (a << sh) & mask;
      OP_SRL:  r = a >> sh;
      OP_SRA:  r = 64'(sa >>> sh) & mask;
      OP_SLTU: r = {63'h0, a < b};
      OP_SLT:  r = {63'h0, sa < sb};
      OP_ADD: begin
        r = a + b; m.cf = r[w]; r = r & mask;
        sr = sa + sb; m.of = (sr > smax) || (sr < smin);
      end
      OP_SUB: begin
        r = (a - b) & mask; m.cf = (a >= b);
        sr = sa - sb; m.of = (sr > smax) || (sr < smin);
      end
      OP_MUL:  r = (a * b) & mask;
      OP_DIVU: if (b == 0) begin r = mask; m.err = 1'b1; end else r = a / b;
      OP_REMU: if (b == 0) begin r = a;    m.err = 1'b1; end else r = a % b;
      default: begin r = '0; m.err = 1'b1; end
    endcase
    m.res = r[31:0];
    m.zf  = (r == 0);
    m.nf  = r[w-1];
    return m;
  endfunction

  function automatic int model_lat(input logic [3:0] o, input logic [31:0] b_in, input int w);
    logic [31:0] b;
    b = (w == 8) ? {24'h0, b_in[7:0]} : b_in;
    if (o == OP_MUL || ((o == OP_DIVU || o == OP_REMU) && b != 0)) return w + 1;
    return 1;
  endfunction

  task automatic set_valid(input logic v);
    if (cur_w == 8) in_valid8 = v; else in_valid32 = v;
  endtask

  task automatic set_ready(input logic v);
    if (cur_w == 8) out_ready8 = v; else out_ready32 = v;
  endtask

  // Issue one op and wait for out_valid; inputs are scrambled right after accept.
  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                       output out_t got, output int lat);
    int guard;
    #1;
    guard = 0;
    while (!o_in_ready && guard < 100) begin @(posedge clk); #1; guard++; end
    check("in_ready before issue", o_in_ready, 1);
    @(negedge clk);
    op = o; din1 = a; din2 = b; set_valid(1'b1);
    lat = 0;
    do begin
      @(posedge clk); #1;
      set_valid(1'b0);
      op = 4'($urandom); din1 = $urandom; din2 = $urandom;
      lat++;
    end while (!o_valid && lat < 200);
    check("out_valid within budget", o_valid, 1);
    got = {o_res, o_zf, o_cf, o_of, o_nf, o_err};
  endtask

  task automatic release_out();
    @(negedge clk); set_ready(1'b1);
    @(posedge clk); #1; set_ready(1'b0);
    check("out_valid drops after handshake", o_valid, 0);
    check("in_ready returns after handshake", o_in_ready, 1);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    out_t got;
    int   lat;
    cur_w = v.w;
    issue(v.op, v.a, v.b, got, lat);
    check($sformatf("%s w%0d op%b result/flags", tag, v.w, v.op), 64'(got), 64'(v.exp));
    check($sformatf("%s w%0d op%b latency", tag, v.w, v.op), 64'(lat), 64'(v.lat));
    release_out();
  endtask

  vec_t tbl[$];

  task automatic add_vec(input int w, input logic [3:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] r,
                         input logic [4:0] zcone, input int lat);
    vec_t v;
    v.w = w; v.op = o; v.a = a; v.b = b; v.exp = {r, zcone}; v.lat = lat;
    tbl.push_back(v);
  endtask

  initial begin
    out_t got, exp_o;
    int   lat;
    logic [31:0] ra, rb;
    logic [3:0]  ro;
    vec_t v;

    // Flags column is {ZF, CF, OF, NF, err}.
    add_vec(32, OP_ADD,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 5'b11000, 1);
    add_vec(32, OP_SUB,  32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 5'b01100, 1);
    add_vec(32, OP_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 5'b00000, 1);
    add_vec(32, OP_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 5'b10000, 1);
    add_vec(32, OP_MUL,  32'h0001_0003, 32'h0000_0005, 32'h0005_000F, 5'b00000, 33);
    add_vec(32, OP_MUL,  32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE, 5'b00010, 33);
    add_vec(32, OP_DIVU, 32'd100,       32'd7,         32'd14,        5'b00000, 33);
    add_vec(32, OP_REMU, 32'd100,       32'd7,         32'd2,         5'b00000, 33);
    add_vec(32, OP_DIVU, 32'd5,         32'd0,         32'hFFFF_FFFF, 5'b00011, 1);
    add_vec(32, OP_REMU, 32'd5,         32'd0,         32'd5,         5'b00001, 1);
    add_vec(32, OP_XOR,  32'hA5A5_A5A5, 32'hFFFF_0000, 32'h5A5A_A5A5, 5'b00000, 1);
    add_vec(32, OP_NOR,  32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 5'b00010, 1);
    add_vec(32, OP_OR,   32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 5'b10000, 1);
    add_vec(32, OP_SRL,  32'h8000_0000, 32'd31,        32'h0000_0001, 5'b00000, 1);
    add_vec(32, OP_SLL,  32'h0000_0001, 32'h0000_0021, 32'h0000_0002, 5'b00000, 1);
    add_vec(32, OP_ADD,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 5'b00110, 1);
    add_vec(32, OP_SUB,  32'h0000_0001, 32'h0000_0002, 32'hFFFF_FFFF, 5'b00010, 1);
    add_vec(32, 4'b1110, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000, 5'b10001, 1);
    add_vec(8,  OP_SRA,  32'h80,        32'd3,         32'hF0,        5'b00010, 1);
    add_vec(8,  4'b1111, 32'h55,        32'hAA,        32'h00,        5'b10001, 1);
    add_vec(8,  OP_MUL,  32'h0F,        32'h11,        32'hFF,        5'b00010, 9);
    add_vec(8,  OP_MUL,  32'h10,        32'h10,        32'h00,        5'b10000, 9);
    add_vec(8,  OP_DIVU, 32'hC8,        32'h07,        32'h1C,        5'b00000, 9);
    add_vec(8,  OP_ADD,  32'hFF,        32'h01,        32'h00,        5'b11000, 1);

    rst_n = 1'b0; cur_w = 32; op = '0; din1 = '0; din2 = '0;
    in_valid32 = 1'b0; in_valid8 = 1'b0; out_ready32 = 1'b0; out_ready8 = 1'b0;
    repeat (3) @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      cur_w = (k == 0) ? 32 : 8;
      #1;
      check($sformatf("reset w%0d result", cur_w), o_res, 0);
      check($sformatf("reset w%0d flags", cur_w), {o_zf, o_cf, o_of, o_nf, o_err}, 5'b10000);
      check($sformatf("reset w%0d handshake", cur_w), {o_valid, o_in_ready}, 2'b01);
    end
    @(negedge clk); rst_n = 1'b1;

    // Result held with out_ready low while a competing request is ignored.
    cur_w = 32;
    issue(OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, got, lat);
    check("hold first ADD result", 64'(got), 64'({32'h0, 5'b11000}));
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      op = OP_SUB; din1 = $urandom; din2 = $urandom; set_valid(1'b1);
      @(posedge clk); #1;
      check("hold stable outputs", {o_valid, o_in_ready, o_res, o_zf, o_cf, o_of, o_nf, o_err},
            {1'b1, 1'b0, 32'h0, 5'b11000});
    end
    set_valid(1'b0);
    release_out();

    foreach (tbl[i]) run_vec(tbl[i], "vec");

    // Reset mid-multiply aborts without ever producing a result.
    cur_w = 32;
    @(negedge clk);
    op = OP_MUL; din1 = 32'h0000_1234; din2 = 32'h0000_5678; set_valid(1'b1);
    @(posedge clk); #1; set_valid(1'b0);
    check("mul busy in_ready", o_in_ready, 0);
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort handshake", {o_valid, o_in_ready}, 2'b01);
    check("abort result", {o_res, o_zf}, {32'h0, 1'b1});
    @(negedge clk); rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("no result after abort", o_valid, 0);
    v.w = 32; v.op = OP_AND; v.a = 32'hF0F0_F0F0; v.b = 32'hFF00_FF00;
    v.exp = {32'hF000_F000, 5'b00010}; v.lat = 1;
    run_vec(v, "post-reset");

    for (int i = 0; i < 160; i++) begin
      cur_w = (i % 4 == 3) ? 8 : 32;
      ro = 4'($urandom_range(15));
      ra = $urandom;
      case ($urandom_range(3))
        0:       rb = 32'h0;
        1:       rb = $urandom_range(15);
        default: rb = $urandom;
      endcase
      exp_o = model(ro, ra, rb, cur_w);
      issue(ro, ra, rb, got, lat);
      check($sformatf("rand w%0d op%b a=%h b=%h", cur_w, ro, ra, rb), 64'(got), 64'(exp_o));
      check($sformatf("rand w%0d op%b latency", cur_w, ro), 64'(lat),
            64'(model_lat(ro, rb, cur_w)));
      release_out();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
